// File: rtl/fc_instr_fetch_bridge_if.sv
// Instruction fetch bus: request/grant address channel plus response
// channel (rvalid, rdata, err).
//   master: drives req/addr, receives gnt/rvalid/rdata/err
//   slave : receives req/addr, drives gnt/rvalid/rdata/err
interface fc_instr_fetch_bridge_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned RDATA_WIDTH = 32
);
  logic                   req;
  logic [ADDR_WIDTH-1:0]  addr;
  logic                   gnt;
  logic                   rvalid;
  logic [RDATA_WIDTH-1:0] rdata;
  logic                   err;

  modport master (
    output req, addr,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/fc_instr_fetch_bridge.sv
// Registered bridge from the FC core instruction port to the L2 instruction
// master. The request path is cut by a request register, at most
// MAX_OUTSTANDING fetches are in flight, and every in-flight address is kept
// so that an L2 error response can be logged with its faulting address.
//
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   core          : core-side bus (slave); core.err carries the L2 error flag
//   l2            : L2-side bus (master); l2.err is the L2 opc/error flag
//   err_cnt_o     : saturating count of error responses
//   err_addr_o    : address of the most recent error response
//   proto_err_o   : sticky, response seen with nothing outstanding
//
// Optional feature: define FC_INSTR_BRIDGE_RSP_REG_EN to register the
// response path (one extra cycle of response latency).
module fc_instr_fetch_bridge #(
  parameter int unsigned RDATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  fc_instr_fetch_bridge_if.slave  core,
  fc_instr_fetch_bridge_if.master l2,
  output logic [7:0]              err_cnt_o,
  output logic [ADDR_WIDTH-1:0]   err_addr_o,
  output logic                    proto_err_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTSTANDING - 1);

  logic                  req_v_q, req_v_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  // cnt also serves as the address FIFO fill level: both move on the same events.
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] fifo_q [MAX_OUTSTANDING];
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  proto_err_q, proto_err_d;

  logic gnt, handshake, fifo_empty, rsp_pop, rsp_spurious;

  // No same-cycle credit return: a response does not free a slot until the next cycle.
  assign gnt          = core.req & (~req_v_q | l2.gnt) & (cnt_q < CntMax);
  assign handshake    = core.req & gnt;
  assign fifo_empty   = (cnt_q == '0);
  assign rsp_pop      = l2.rvalid & ~fifo_empty;
  assign rsp_spurious = l2.rvalid & fifo_empty;

  assign core.gnt    = gnt;
  assign l2.req      = req_v_q;
  assign l2.addr     = req_addr_q;
  assign err_cnt_o   = err_cnt_q;
  assign err_addr_o  = err_addr_q;
  assign proto_err_o = proto_err_q;

  always_comb begin
    req_v_d     = req_v_q;
    req_addr_d  = req_addr_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    err_cnt_d   = err_cnt_q;
    err_addr_d  = err_addr_q;
    proto_err_d = proto_err_q;

    if (handshake) begin
      req_v_d    = 1'b1;
      req_addr_d = core.addr;
      wr_ptr_d   = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    end else if (l2.gnt) begin
      req_v_d = 1'b0;
    end

    if (rsp_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
      // Log the popped head; a same-cycle push never reaches the head here.
      if (l2.err) begin
        err_addr_d = fifo_q[rd_ptr_q];
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
    end

    if (rsp_spurious) proto_err_d = 1'b1;

    case ({handshake, rsp_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_v_q     <= 1'b0;
      req_addr_q  <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_cnt_q   <= '0;
      err_addr_q  <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= '0;
    end else begin
      req_v_q     <= req_v_d;
      req_addr_q  <= req_addr_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_cnt_q   <= err_cnt_d;
      err_addr_q  <= err_addr_d;
      proto_err_q <= proto_err_d;
      if (handshake) fifo_q[wr_ptr_q] <= core.addr;
    end
  end

`ifdef FC_INSTR_BRIDGE_RSP_REG_EN
  logic                   rsp_valid_q;
  logic [RDATA_WIDTH-1:0] rsp_rdata_q;
  logic                   rsp_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= l2.rvalid;
      if (l2.rvalid) begin
        rsp_rdata_q <= l2.rdata;
        rsp_err_q   <= l2.err;
      end
    end
  end

  assign core.rvalid = rsp_valid_q;
  assign core.rdata  = rsp_rdata_q;
  assign core.err    = rsp_err_q;
`else
  assign core.rvalid = l2.rvalid;
  assign core.rdata  = l2.rdata;
  assign core.err    = l2.err;
`endif

endmodule

// File: tb/tb_fc_instr_fetch_bridge.sv
module tb_fc_instr_fetch_bridge;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXO = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fc_instr_fetch_bridge_if #(.ADDR_WIDTH(AW), .RDATA_WIDTH(DW)) core_if ();
  fc_instr_fetch_bridge_if #(.ADDR_WIDTH(AW), .RDATA_WIDTH(DW)) l2_if ();

  logic [7:0]    err_cnt;
  logic [AW-1:0] err_addr;
  logic          proto_err;

  fc_instr_fetch_bridge #(
    .RDATA_WIDTH     (DW),
    .ADDR_WIDTH      (AW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .core        (core_if),
    .l2          (l2_if),
    .err_cnt_o   (err_cnt),
    .err_addr_o  (err_addr),
    .proto_err_o (proto_err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of accepted-but-unanswered addresses plus the
  // pending L2 request and the logs.
  logic [AW-1:0] m_q[$];
  bit            m_req_v;
  logic [AW-1:0] m_req_addr;
  int            m_err_cnt;
  logic [AW-1:0] m_err_addr;
  bit            m_proto;
  bit            m_rv;
  logic [DW-1:0] m_rd;
  bit            m_re;

  task automatic model_reset();
    m_q.delete();
    m_req_v = 0; m_req_addr = '0;
    m_err_cnt = 0; m_err_addr = '0; m_proto = 0;
    m_rv = 0; m_rd = '0; m_re = 0;
  endtask

  function automatic bit exp_gnt();
    return core_if.req && (!m_req_v || l2_if.gnt) && (m_q.size() < int'(MAXO));
  endfunction

  function automatic bit exp_rvalid();
`ifdef FC_INSTR_BRIDGE_RSP_REG_EN
    return m_rv;
`else
    return l2_if.rvalid;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_rdata();
`ifdef FC_INSTR_BRIDGE_RSP_REG_EN
    return m_rd;
`else
    return l2_if.rdata;
`endif
  endfunction

  function automatic bit exp_err();
`ifdef FC_INSTR_BRIDGE_RSP_REG_EN
    return m_re;
`else
    return l2_if.err;
`endif
  endfunction

  // Fetches already handed to L2 and still waiting for their response.
  function automatic int issued();
    return m_q.size() - (m_req_v ? 1 : 0);
  endfunction

  task automatic drive(input bit req, input logic [AW-1:0] addr, input bit gnt,
                       input bit rv, input logic [DW-1:0] rd, input bit re);
    core_if.req = req; core_if.addr = addr;
    l2_if.gnt = gnt; l2_if.rvalid = rv; l2_if.rdata = rd; l2_if.err = re;
  endtask

  // Advance one clock; model consumes the inputs present at the edge.
  task automatic tick();
    bit hs, pop, spur, l2g, rv, re;
    logic [AW-1:0] a, head;
    logic [DW-1:0] rd;
    hs = core_if.req && exp_gnt();
    pop = l2_if.rvalid && (m_q.size() > 0);
    spur = l2_if.rvalid && (m_q.size() == 0);
    a = core_if.addr; l2g = l2_if.gnt; rv = l2_if.rvalid; rd = l2_if.rdata; re = l2_if.err;
    @(posedge clk);
    if (pop) begin
      head = m_q.pop_front();
      if (re) begin
        m_err_addr = head;
        if (m_err_cnt < 255) m_err_cnt++;
      end
    end
    if (spur) m_proto = 1;
    if (hs) begin
      m_q.push_back(a); m_req_v = 1; m_req_addr = a;
    end else if (l2g) begin
      m_req_v = 0;
    end
    m_rv = rv;
    if (rv) begin m_rd = rd; m_re = re; end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(0, '0, 0, 0, '0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, '0, 0, 0, '0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (l2_if.req !== 1'b0) begin failures++; $display("FAIL reset_l2_req got=%0b exp=0", l2_if.req); end
    checks++; if (l2_if.addr !== '0) begin failures++; $display("FAIL reset_l2_add got=%0h exp=0", l2_if.addr); end
    checks++; if (core_if.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%0b exp=0", core_if.rvalid); end
    checks++; if (core_if.rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", core_if.rdata); end
    checks++; if (core_if.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", core_if.err); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (err_addr !== '0) begin failures++; $display("FAIL reset_err_addr got=%0h exp=0", err_addr); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto got=%0b exp=0", proto_err); end
    checks++; if (core_if.gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt_noreq got=%0b exp=0", core_if.gnt); end
    core_if.req = 1'b1;
    #1;
    checks++; if (core_if.gnt !== 1'b1) begin failures++; $display("FAIL reset_gnt_req got=%0b exp=1", core_if.gnt); end
    core_if.req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_fetch(input string tag);
    drive(1, 32'h1C00_8080, 1, 0, '0, 0);
    @(negedge clk);
    checks++; if (core_if.gnt !== 1'b1) begin failures++; $display("FAIL %s_gnt got=%0b exp=1", tag, core_if.gnt); end
    tick();
    drive(0, '0, 1, 0, '0, 0);
    @(negedge clk);
    checks++; if (l2_if.req !== 1'b1) begin failures++; $display("FAIL %s_l2_req got=%0b exp=1", tag, l2_if.req); end
    checks++; if (l2_if.addr !== 32'h1C00_8080) begin failures++; $display("FAIL %s_l2_add got=%0h exp=1c008080", tag, l2_if.addr); end
    tick();
    @(negedge clk);
    checks++; if (l2_if.req !== 1'b0) begin failures++; $display("FAIL %s_l2_req_drop got=%0b exp=0", tag, l2_if.req); end
    tick();
    drive(0, '0, 1, 1, 32'h0000_0013, 0);
    @(negedge clk);
`ifdef FC_INSTR_BRIDGE_RSP_REG_EN
    checks++; if (core_if.rvalid !== 1'b0) begin failures++; $display("FAIL %s_rvalid_early got=%0b exp=0", tag, core_if.rvalid); end
`else
    checks++; if (core_if.rvalid !== 1'b1) begin failures++; $display("FAIL %s_rvalid got=%0b exp=1", tag, core_if.rvalid); end
    checks++; if (core_if.rdata !== 32'h13) begin failures++; $display("FAIL %s_rdata got=%0h exp=13", tag, core_if.rdata); end
`endif
    tick();
    drive(0, '0, 1, 0, '0, 0);
    @(negedge clk);
`ifdef FC_INSTR_BRIDGE_RSP_REG_EN
    checks++; if (core_if.rvalid !== 1'b1) begin failures++; $display("FAIL %s_rvalid got=%0b exp=1", tag, core_if.rvalid); end
    checks++; if (core_if.rdata !== 32'h13) begin failures++; $display("FAIL %s_rdata got=%0h exp=13", tag, core_if.rdata); end
`else
    checks++; if (core_if.rvalid !== 1'b0) begin failures++; $display("FAIL %s_rvalid_late got=%0b exp=0", tag, core_if.rvalid); end
`endif
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL %s_proto got=%0b exp=0", tag, proto_err); end
    tick();
  endtask

  task automatic test_credit_limit();
    bit exp_g [5] = '{1, 1, 0, 0, 0};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h2000_0000 + 32'(4 * i), 1, 0, '0, 0);
      @(negedge clk);
      checks++;
      if (core_if.gnt !== exp_g[i]) begin
        failures++; $display("FAIL credit_gnt%0d got=%0b exp=%0b", i, core_if.gnt, exp_g[i]);
      end
      tick();
    end
    // Response while full: no same-cycle credit.
    drive(1, 32'h2000_0100, 1, 1, 32'hAAAA_0001, 0);
    @(negedge clk);
    checks++; if (core_if.gnt !== 1'b0) begin failures++; $display("FAIL credit_same_cycle got=%0b exp=0", core_if.gnt); end
    tick();
    drive(1, 32'h2000_0100, 1, 0, '0, 0);
    @(negedge clk);
    checks++; if (core_if.gnt !== 1'b1) begin failures++; $display("FAIL credit_return got=%0b exp=1", core_if.gnt); end
    tick();
  endtask

  task automatic test_l2_stall();
    apply_reset();
    drive(1, 32'h3000_0040, 0, 0, '0, 0);
    @(negedge clk);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h3000_0044, 0, 0, '0, 0);
      @(negedge clk);
      checks++; if (core_if.gnt !== 1'b0) begin failures++; $display("FAIL stall_gnt%0d got=%0b exp=0", i, core_if.gnt); end
      checks++; if (l2_if.req !== 1'b1) begin failures++; $display("FAIL stall_req%0d got=%0b exp=1", i, l2_if.req); end
      checks++; if (l2_if.addr !== 32'h3000_0040) begin failures++; $display("FAIL stall_add%0d got=%0h exp=30000040", i, l2_if.addr); end
      tick();
    end
    drive(1, 32'h3000_0044, 1, 0, '0, 0);
    @(negedge clk);
    checks++; if (core_if.gnt !== 1'b1) begin failures++; $display("FAIL stall_resume_gnt got=%0b exp=1", core_if.gnt); end
    tick();
    drive(0, '0, 0, 0, '0, 0);
    @(negedge clk);
    checks++; if (l2_if.addr !== 32'h3000_0044) begin failures++; $display("FAIL stall_resume_add got=%0h exp=30000044", l2_if.addr); end
    tick();
  endtask

  task automatic test_error_logging();
    int n_err;
    int cyc;
    bit rv;
    apply_reset();
    drive(1, 32'h1A00_0000, 1, 0, '0, 0);
    @(negedge clk); tick();
    drive(1, 32'h1A00_0004, 1, 0, '0, 0);
    @(negedge clk);
    checks++; if (core_if.gnt !== 1'b1) begin failures++; $display("FAIL errlog_gnt2 got=%0b exp=1", core_if.gnt); end
    tick();
    drive(0, '0, 1, 1, 32'h1111_2222, 0);
    @(negedge clk); tick();
    drive(0, '0, 1, 1, 32'h3333_4444, 1);
    @(negedge clk);
`ifndef FC_INSTR_BRIDGE_RSP_REG_EN
    checks++; if (core_if.err !== 1'b1) begin failures++; $display("FAIL errlog_core_err got=%0b exp=1", core_if.err); end
`endif
    tick();
    drive(0, '0, 1, 0, '0, 0);
    @(negedge clk);
`ifdef FC_INSTR_BRIDGE_RSP_REG_EN
    checks++; if (core_if.err !== 1'b1) begin failures++; $display("FAIL errlog_core_err got=%0b exp=1", core_if.err); end
`endif
    checks++; if (err_addr !== 32'h1A00_0004) begin failures++; $display("FAIL errlog_addr got=%0h exp=1a000004", err_addr); end
    checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL errlog_cnt got=%0d exp=1", err_cnt); end
    tick();
    // Saturation: stream error responses until 300 in total.
    n_err = 1;
    cyc = 0;
    while (n_err < 300 && cyc < 3000) begin
      rv = issued() > 0;
      drive(1, 32'h1B00_0000 + 32'(4 * cyc), 1, rv, 32'(cyc), 1);
      if (rv) n_err++;
      @(negedge clk); tick();
      cyc++;
    end
    drive(0, '0, 0, 0, '0, 0);
    @(negedge clk);
    checks++; if (n_err < 300) begin failures++; $display("FAIL errlog_budget got=%0d exp=300", n_err); end
    checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL errlog_saturate got=%0d exp=255", err_cnt); end
    tick();
  endtask

  task automatic test_random();
    bit rq, g, rv, re;
    apply_reset();
    for (int i = 0; i < 500; i++) begin
      rq = ($urandom_range(0, 3) != 0);
      g  = ($urandom_range(0, 9) < 7);
      rv = (issued() > 0) && ($urandom_range(0, 1) == 1);
      re = ($urandom_range(0, 3) == 0);
      drive(rq, $urandom, g, rv, $urandom, re);
      @(negedge clk);
      checks++; if (core_if.gnt !== exp_gnt()) begin failures++; $display("FAIL rand_gnt c%0d got=%0b exp=%0b", i, core_if.gnt, exp_gnt()); end
      checks++; if (l2_if.req !== m_req_v) begin failures++; $display("FAIL rand_l2_req c%0d got=%0b exp=%0b", i, l2_if.req, m_req_v); end
      if (m_req_v) begin
        checks++; if (l2_if.addr !== m_req_addr) begin failures++; $display("FAIL rand_l2_add c%0d got=%0h exp=%0h", i, l2_if.addr, m_req_addr); end
      end
      checks++; if (core_if.rvalid !== exp_rvalid()) begin failures++; $display("FAIL rand_rvalid c%0d got=%0b exp=%0b", i, core_if.rvalid, exp_rvalid()); end
      if (exp_rvalid()) begin
        checks++; if (core_if.rdata !== exp_rdata()) begin failures++; $display("FAIL rand_rdata c%0d got=%0h exp=%0h", i, core_if.rdata, exp_rdata()); end
        checks++; if (core_if.err !== exp_err()) begin failures++; $display("FAIL rand_err c%0d got=%0b exp=%0b", i, core_if.err, exp_err()); end
      end
      checks++; if (err_cnt !== 8'(m_err_cnt)) begin failures++; $display("FAIL rand_err_cnt c%0d got=%0d exp=%0d", i, err_cnt, m_err_cnt); end
      checks++; if (err_addr !== m_err_addr) begin failures++; $display("FAIL rand_err_addr c%0d got=%0h exp=%0h", i, err_addr, m_err_addr); end
      checks++; if (proto_err !== m_proto) begin failures++; $display("FAIL rand_proto c%0d got=%0b exp=%0b", i, proto_err, m_proto); end
      tick();
    end
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    drive(1, 32'h4000_0100, 1, 0, '0, 0);
    @(negedge clk); tick();
    drive(1, 32'h4000_0104, 1, 0, '0, 0);
    @(negedge clk); tick();
    drive(0, '0, 0, 0, '0, 0);
    rst = 1'b1;
    #2;
    checks++; if (l2_if.req !== 1'b0) begin failures++; $display("FAIL midrst_l2_req got=%0b exp=0", l2_if.req); end
    checks++; if (l2_if.addr !== '0) begin failures++; $display("FAIL midrst_l2_add got=%0h exp=0", l2_if.addr); end
    checks++; if (core_if.rvalid !== 1'b0) begin failures++; $display("FAIL midrst_rvalid got=%0b exp=0", core_if.rvalid); end
    checks++; if (core_if.gnt !== 1'b0) begin failures++; $display("FAIL midrst_gnt got=%0b exp=0", core_if.gnt); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL midrst_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL midrst_proto got=%0b exp=0", proto_err); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_single_fetch("midrst_refetch");
  endtask

  task automatic test_spurious();
    bit exp_g [3] = '{1, 1, 0};
    apply_reset();
    drive(0, '0, 0, 1, 32'hDEAD_BEEF, 1);
    @(negedge clk); tick();
    drive(0, '0, 0, 0, '0, 0);
    @(negedge clk);
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL spur_proto got=%0b exp=1", proto_err); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL spur_err_cnt got=%0d exp=0", err_cnt); end
    tick();
    // cnt must still be 0: exactly MAX grants fit.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h5000_0000 + 32'(4 * i), 1, 0, '0, 0);
      @(negedge clk);
      checks++;
      if (core_if.gnt !== exp_g[i]) begin
        failures++; $display("FAIL spur_gnt%0d got=%0b exp=%0b", i, core_if.gnt, exp_g[i]);
      end
      tick();
    end
    drive(0, '0, 0, 0, '0, 0);
    @(negedge clk);
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL spur_sticky got=%0b exp=1", proto_err); end
    tick();
  endtask

  initial begin
    drive(0, '0, 0, 0, '0, 0);
    model_reset();
    test_reset();
    test_single_fetch("single");
    test_credit_limit();
    test_l2_stall();
    test_error_logging();
    test_random();
    test_reset_mid_op();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
